// File: rtl/zc_pkg.sv
// Shared types and sizing helpers for the zero_count_unit bit-count datapath.
package zc_pkg;

  typedef enum logic [1:0] {
    ZC_CLZ  = 2'd0,
    ZC_CTZ  = 2'd1,
    ZC_CPOP = 2'd2
  } zc_op_e;

  typedef enum logic [1:0] {
    ZC_IDLE,
    ZC_BUSY,
    ZC_DONE
  } zc_state_e;

  // Count of 0..xlen inclusive needs one bit more than log2(xlen).
  function automatic int zc_res_w(input int xlen);
    return $clog2(xlen) + 1;
  endfunction

  function automatic int zc_num_chunks(input int xlen, input int chunk);
    return xlen / chunk;
  endfunction

  // The reserved encoding executes as CLZ.
  function automatic zc_op_e zc_decode_op(input logic [1:0] raw);
    case (raw)
      2'd1:    return ZC_CTZ;
      2'd2:    return ZC_CPOP;
      default: return ZC_CLZ;
    endcase
  endfunction

endpackage

// File: rtl/zc_chunk_count.sv
// Combinational per-chunk counter: zero flag, leading-zero count and popcount.
// The count not selected by pop_mode is forced to zero so the caller can simply sum both.
module zc_chunk_count #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0]      chunk,
  input  logic                  pop_mode,
  output logic                  zero,
  output logic [$clog2(CHUNK):0] lz_cnt,
  output logic [$clog2(CHUNK):0] pop_cnt
);

  localparam int CNT_W = $clog2(CHUNK) + 1;

  logic [CNT_W-1:0] lz;
  logic [CNT_W-1:0] pop;
  logic             found;

  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
    lz    = CNT_W'(CHUNK);
    pop   = '0;
    found = 1'b0;
    for (int i = CHUNK - 1; i >= 0; i--) begin
      if (chunk[i]) begin
        pop = pop + CNT_W'(1);
        if (!found) begin
          lz    = CNT_W'(CHUNK - 1 - i);
          found = 1'b1;
        end
      end
    end
  end

  assign zero    = ~|chunk;
  assign lz_cnt  = pop_mode ? '0 : lz;
  assign pop_cnt = pop_mode ? pop : '0;

endmodule

// File: rtl/zero_count_unit.sv
// Iterative CLZ/CTZ/CPOP unit scanning CHUNK bits per cycle with valid/ready on both sides.
// Optional ZERO_SHORTCUT_EN: a zero operand skips the scan and completes straight from accept.
module zero_count_unit
  import zc_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CHUNK = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            op,
  input  logic [XLEN-1:0]       operand,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [$clog2(XLEN):0] result
);

  localparam int RES_W  = zc_res_w(XLEN);
  localparam int NCHUNK = zc_num_chunks(XLEN, CHUNK);
  localparam int ITER_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int CNT_W  = $clog2(CHUNK) + 1;

  zc_state_e         state_q, state_d;
  zc_op_e            op_q, op_d;
  logic [XLEN-1:0]   shreg_q, shreg_d;
  logic [RES_W-1:0]  cnt_q, cnt_d;
  logic [ITER_W-1:0] iter_q, iter_d;

  logic [XLEN-1:0]   operand_rev;
  logic              accept;
  logic              chunk_zero;
  logic [CNT_W-1:0]  lz_cnt;
  logic [CNT_W-1:0]  pop_cnt;
  zc_op_e            op_dec;

  zc_chunk_count #(.CHUNK(CHUNK)) u_chunk (
    .chunk    (shreg_q[XLEN-1 -: CHUNK]),
    .pop_mode (op_q == ZC_CPOP),
    .zero     (chunk_zero),
    .lz_cnt   (lz_cnt),
    .pop_cnt  (pop_cnt)
  );

  assign in_ready  = (state_q == ZC_IDLE) && !flush;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ZC_DONE);
  assign result    = cnt_q;
  assign op_dec    = zc_decode_op(op);

  // CTZ reuses the leading-zero scan on the bit-reversed operand.
  always_comb begin
    operand_rev = '0;
    for (int i = 0; i < XLEN; i++) operand_rev[i] = operand[XLEN-1-i];
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    iter_d  = iter_q;
    if (flush) begin
      state_d = ZC_IDLE;
    end else begin
      case (state_q)
        ZC_IDLE: begin
          if (accept) begin
            op_d    = op_dec;
            shreg_d = (op_dec == ZC_CTZ) ? operand_rev : operand;
            cnt_d   = '0;
            iter_d  = '0;
            state_d = ZC_BUSY;
`ifdef ZERO_SHORTCUT_EN
            if (~|operand) begin
              cnt_d   = (op_dec == ZC_CPOP) ? '0 : RES_W'(XLEN);
              state_d = ZC_DONE;
            end
`endif
          end
        end
        ZC_BUSY: begin
          // Only one of the two counts is non-zero for the active op.
          cnt_d = cnt_q + RES_W'(lz_cnt) + RES_W'(pop_cnt);
          if (op_q == ZC_CPOP || chunk_zero) begin
            shreg_d = shreg_q << CHUNK;
            iter_d  = iter_q + ITER_W'(1);
          end
          if ((op_q != ZC_CPOP && !chunk_zero) || iter_q == ITER_W'(NCHUNK - 1))
            state_d = ZC_DONE;
        end
        ZC_DONE: begin
          if (out_ready) state_d = ZC_IDLE;
        end
        default: state_d = ZC_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ZC_IDLE;
      op_q    <= ZC_CLZ;
      shreg_q <= '0;
      cnt_q   <= '0;
      iter_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of order.
      state_q <= state_d;
      op_q    <= op_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      iter_q  <= iter_d;
    end
  end

endmodule

// File: tb/tb_zero_count_unit.sv
// Self-checking bench for zero_count_unit: per-cycle comparison against a latency/result model
// plus directed cases with hand-computed results and latencies.
module tb_zero_count_unit;

  localparam int XLEN   = 32;
  localparam int CHUNK  = 4;
  localparam int NCHUNK = XLEN / CHUNK;
`ifdef ZERO_SHORTCUT_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 9;
`endif

  logic            clk;
  logic            reset;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      op;
  logic [XLEN-1:0] operand;
  logic            out_valid;
  logic            out_ready;
  logic [5:0]      result;

  int n_tests = 0;
  int n_fail  = 0;

  zero_count_unit #(.XLEN(XLEN), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .operand   (operand),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference results straight from the op definitions.
  function automatic int model_res(input logic [1:0] o, input logic [XLEN-1:0] v);
    int n;
    n = XLEN;
    case (o)
      2'd1: begin
        for (int i = 0; i < XLEN; i++) if (v[i]) begin n = i; break; end
      end
      2'd2: n = $countones(v);
      default: begin
        for (int i = 0; i < XLEN; i++) if (v[XLEN-1-i]) begin n = i; break; end
      end
    endcase
    return n;
  endfunction

  // Number of BUSY cycles the op occupies.
  function automatic int model_busy(input logic [1:0] o, input logic [XLEN-1:0] v);
    if (v == '0) return (ZLAT == 1) ? 0 : NCHUNK;
    if (o == 2'd2) return NCHUNK;
    return model_res(o, v) / CHUNK + 1;
  endfunction

  typedef enum {M_IDLE, M_BUSY, M_DONE} m_state_e;
  m_state_e m_state;
  int       m_left;
  int       m_res;
  bit       m_valid;
  bit       m_known;
  bit       m_live = 1'b0;

  always @(posedge clk) begin
    int k;
    if (reset) begin
      m_state <= M_IDLE;
      m_valid <= 1'b0;
      m_res   <= 0;
      m_known <= 1'b1;
      m_live  <= 1'b1;
    end else if (flush) begin
      m_state <= M_IDLE;
      m_valid <= 1'b0;
      if (m_state == M_BUSY) m_known <= 1'b0;
    end else begin
      case (m_state)
        M_IDLE: if (in_valid) begin
          k = model_busy(op, operand);
          m_res <= model_res(op, operand);
          if (k == 0) begin
            m_state <= M_DONE;
            m_valid <= 1'b1;
            m_known <= 1'b1;
          end else begin
            m_state <= M_BUSY;
            m_left  <= k;
            m_known <= 1'b0;
          end
        end
        M_BUSY: begin
          if (m_left == 1) begin
            m_state <= M_DONE;
            m_valid <= 1'b1;
            m_known <= 1'b1;
          end else begin
            m_left <= m_left - 1;
          end
        end
        M_DONE: if (out_ready) begin
          m_state <= M_IDLE;
          m_valid <= 1'b0;
        end
        default: m_state <= M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("cmp_in_ready", in_ready, (m_state == M_IDLE) && !flush);
      check("cmp_out_valid", out_valid, m_valid);
      if (m_known) check("cmp_result", result, m_res);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 2ms");
    $fatal(1);
  end

  // All tasks start and end just after a rising edge unless noted.
  task automatic start(input logic [1:0] o, input logic [XLEN-1:0] v);
    op       = o;
    operand  = v;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op       = 2'($urandom);
    operand  = $urandom;
  endtask

  // Ends at the falling edge where out_valid was seen, or after the cycle budget.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic recover();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [XLEN-1:0] v,
                        input int exp_res, input int exp_lat, input int hold);
    int lat;
    logic [5:0] held;
    start(o, v);
    wait_valid(lat);
    check({name, "_latency"}, lat, exp_lat);
    if (lat < 0) begin
      @(posedge clk); #1;
      recover();
      return;
    end
    check({name, "_result"}, result, exp_res);
    held = result;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, "_held_result"}, result, held);
      check({name, "_held_valid"}, out_valid, 1);
      check({name, "_held_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({name, "_idle_in_ready"}, in_ready, 1);
    check({name, "_idle_out_valid"}, out_valid, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    op        = 2'd0;
    operand   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_result", result, 0);
    check("reset_in_ready", in_ready, 1);
    @(posedge clk); #1;

    run_op("clz_msb",   2'd0, 32'h8000_0000,  0, 2,    0);
    run_op("clz_lsb",   2'd0, 32'h0000_0001, 31, 9,    0);
    run_op("ctz_bp",    2'd1, 32'h0000_0100,  8, 4,    5);
    run_op("ctz_zero",  2'd1, 32'h0000_0000, 32, ZLAT, 0);
    run_op("cpop_zero", 2'd2, 32'h0000_0000,  0, ZLAT, 0);
    run_op("cpop_ones", 2'd2, 32'hFFFF_FFFF, 32, 9,    0);
    run_op("cpop_mix",  2'd2, 32'hA5A5_0F01, 13, 9,    0);
    run_op("rsvd_op",   2'd3, 32'h00F0_0000,  8, 4,    0);

    // Flush during the third BUSY cycle of a CPOP.
    start(2'd2, 32'hFFFF_0000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_busy_out_valid", out_valid, 0);
    check("flush_busy_in_ready", in_ready, 1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("flush_busy_no_result", out_valid, 0);
    @(posedge clk); #1;

    // Flush together with a request in IDLE: request must be dropped.
    flush    = 1'b1;
    in_valid = 1'b1;
    op       = 2'd0;
    operand  = 32'h8000_0000;
    @(negedge clk);
    check("flush_idle_in_ready", in_ready, 0);
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("flush_idle_not_accepted", out_valid, 0);
    check("flush_idle_ready_after", in_ready, 1);
    @(posedge clk); #1;

    // Reset mid-BUSY.
    start(2'd0, 32'h0000_0001);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy_out_valid", out_valid, 0);
    check("rst_busy_result", result, 0);
    check("rst_busy_in_ready", in_ready, 1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("rst_busy_no_result", out_valid, 0);
    @(posedge clk); #1;

    // Reset while holding a result in DONE.
    start(2'd2, 32'hFFFF_FFFF);
    wait_valid(lat);
    check("rst_done_latency", lat, 9);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_done_out_valid", out_valid, 0);
    check("rst_done_result", result, 0);
    @(posedge clk); #1;

    // Randomized traffic; the per-cycle compare process does the checking.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      op        = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      reset     = ($urandom_range(0, 199) == 0);
      case ($urandom_range(0, 5))
        0:       operand = '0;
        1:       operand = '1;
        2:       operand = 32'h1 << $urandom_range(0, 31);
        3:       operand = $urandom >> $urandom_range(0, 31);
        default: operand = $urandom;
      endcase
      @(posedge clk); #1;
    end

    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    recover();
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
